// File: rtl/shake_pkg.sv
// Shared types and defaults for the Keccak permutation sequencer.
package shake_pkg;

    localparam int unsigned NUM_ROUNDS_DEF = 24;
    localparam int unsigned ROUND_IDX_W    = 5;
    localparam int unsigned OUT_BLK_W_DEF  = 16;

    typedef enum logic [1:0] {
        PS_RESET       = 2'd0,
        PS_WAIT_BLOCK  = 2'd1,
        PS_PERMUTE     = 2'd2,
        PS_WAIT_OUTPUT = 2'd3
    } permute_state_e;

    // Index of the final round of one permutation.
    function automatic logic [ROUND_IDX_W-1:0] last_round_idx(input int unsigned num_rounds);
        return ROUND_IDX_W'(num_rounds - 1);
    endfunction

endpackage

// File: rtl/permute_fsm_if.sv
// Control bundle between the permutation sequencer and the SIPO/state/PISO datapath.
interface permute_fsm_if
    import shake_pkg::*;
#(
    parameter int unsigned OUT_BLK_W = OUT_BLK_W_DEF
);

    logic                   input_buffer_ready;
    logic                   last_block_in_buffer;
    logic [OUT_BLK_W-1:0]   out_blocks;
    logic                   input_buffer_ready_clr;
    logic                   state_reset;
    logic                   absorb_enable;
    logic                   round_enable;
    logic [ROUND_IDX_W-1:0] round_index;
    logic                   output_buffer_ready;
    logic                   output_buffer_load;
    logic                   output_buffer_ready_wr;
    logic                   last_output_block;

    // Sequencer side.
    modport master (
        input  input_buffer_ready,
        input  last_block_in_buffer,
        input  out_blocks,
        input  output_buffer_ready,
        output input_buffer_ready_clr,
        output state_reset,
        output absorb_enable,
        output round_enable,
        output round_index,
        output output_buffer_load,
        output output_buffer_ready_wr,
        output last_output_block
    );

    // Datapath side.
    modport slave (
        output input_buffer_ready,
        output last_block_in_buffer,
        output out_blocks,
        output output_buffer_ready,
        input  input_buffer_ready_clr,
        input  state_reset,
        input  absorb_enable,
        input  round_enable,
        input  round_index,
        input  output_buffer_load,
        input  output_buffer_ready_wr,
        input  last_output_block
    );

endinterface

// File: rtl/permute_fsm.sv
// Mealy sequencer for absorb / Keccak-f rounds / squeeze of one message at a time.
module permute_fsm
    import shake_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int unsigned OUT_BLK_W  = OUT_BLK_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    permute_fsm_if.master bus
);

    localparam logic [ROUND_IDX_W-1:0] LAST_ROUND = last_round_idx(NUM_ROUNDS);
    localparam logic [OUT_BLK_W-1:0]   ONE_BLK    = OUT_BLK_W'(1);

    permute_state_e         state_q, state_d;
    logic [ROUND_IDX_W-1:0] round_q, round_d;
    logic [OUT_BLK_W-1:0]   remaining_q, remaining_d;
    logic                   last_flag_q, last_flag_d;

    logic                   in_clr;
    logic                   st_reset;
    logic                   absorb;
    logic                   round_en;
    logic [ROUND_IDX_W-1:0] round_idx;
    logic                   out_load;
    logic                   out_wr;
    logic                   out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PS_RESET;
            round_q     <= '0;
            remaining_q <= '0;
            last_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            remaining_q <= remaining_d;
            last_flag_q <= last_flag_d;
        end
    end

    // Next state and Mealy outputs; everything is held low while rst is high.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        remaining_d = remaining_q;
        last_flag_d = last_flag_q;
        in_clr      = 1'b0;
        st_reset    = 1'b0;
        absorb      = 1'b0;
        round_en    = 1'b0;
        round_idx   = '0;
        out_load    = 1'b0;
        out_wr      = 1'b0;
        out_last    = 1'b0;

        if (!rst) begin
            case (state_q)
                PS_RESET: begin
                    st_reset = 1'b1;
                    state_d  = PS_WAIT_BLOCK;
                end

                PS_WAIT_BLOCK: begin
                    if (bus.input_buffer_ready) begin
                        absorb      = 1'b1;
                        in_clr      = 1'b1;
                        last_flag_d = bus.last_block_in_buffer;
                        round_d     = '0;
                        state_d     = PS_PERMUTE;
                        // A zero request still squeezes one block.
                        if (bus.last_block_in_buffer) begin
                            remaining_d = (bus.out_blocks == '0) ? ONE_BLK : bus.out_blocks;
                        end
                    end
                end

                PS_PERMUTE: begin
                    round_en  = 1'b1;
                    round_idx = round_q;
                    round_d   = round_q + ROUND_IDX_W'(1);
                    if (round_q == LAST_ROUND) begin
                        state_d = last_flag_q ? PS_WAIT_OUTPUT : PS_WAIT_BLOCK;
                    end
                end

                PS_WAIT_OUTPUT: begin
                    if (!bus.output_buffer_ready) begin
                        out_load    = 1'b1;
                        out_wr      = 1'b1;
                        out_last    = (remaining_q == ONE_BLK);
                        remaining_d = remaining_q - ONE_BLK;
                        if (remaining_q == ONE_BLK) begin
                            state_d = PS_RESET;
                        end else begin
                            round_d = '0;
                            state_d = PS_PERMUTE;
                        end
                    end
                end

                default: begin
                    state_d = PS_RESET;
                end
            endcase
        end
    end

    assign bus.input_buffer_ready_clr = in_clr;
    assign bus.state_reset            = st_reset;
    assign bus.absorb_enable          = absorb;
    assign bus.round_enable           = round_en;
    assign bus.round_index            = round_idx;
    assign bus.output_buffer_load     = out_load;
    assign bus.output_buffer_ready_wr = out_wr;
    assign bus.last_output_block      = out_last;

endmodule

// File: tb/tb_permute_fsm.sv
// Randomized bench: each message is a scripted timeline of expected control outputs.
module tb_permute_fsm;
    import shake_pkg::*;

    localparam int unsigned NR  = NUM_ROUNDS_DEF;
    localparam int unsigned OBW = OUT_BLK_W_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    permute_fsm_if #(.OUT_BLK_W(OBW)) bus ();

    permute_fsm #(.NUM_ROUNDS(NR), .OUT_BLK_W(OBW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {clr, state_reset, absorb, round_en, round_index[4:0], load, wr, last}
    function automatic logic [11:0] outs_now();
        return {bus.input_buffer_ready_clr, bus.state_reset, bus.absorb_enable,
                bus.round_enable, bus.round_index, bus.output_buffer_load,
                bus.output_buffer_ready_wr, bus.last_output_block};
    endfunction

    function automatic logic [11:0] ev(input bit clr, input bit sr, input bit ab, input bit re,
                                       input int ri, input bit ld, input bit last);
        logic [4:0] idx;
        idx = 5'(ri);
        return {clr, sr, ab, re, idx, ld, ld, last};
    endfunction

    task automatic tick(input string tag, input logic [11:0] exp);
        @(negedge clk);
        check_eq(tag, 32'(outs_now()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle(input bit quiet);
        if (quiet) begin
            bus.input_buffer_ready   = 1'b0;
            bus.last_block_in_buffer = 1'b0;
            bus.out_blocks           = '0;
            bus.output_buffer_ready  = 1'b0;
        end else begin
            bus.input_buffer_ready   = 1'($urandom_range(0, 1));
            bus.last_block_in_buffer = 1'($urandom_range(0, 1));
            bus.out_blocks           = OBW'($urandom);
            bus.output_buffer_ready  = 1'($urandom_range(0, 1));
        end
    endtask

    // One message: nblk input blocks, ob squeeze blocks requested, bp cycles of PISO stall per load.
    task automatic run_message(input int nblk, input int ob, input int bp, input int abort_round,
                               input bit quiet);
        int eff;
        eff = (ob == 0) ? 1 : ob;
        for (int b = 0; b < nblk; b++) begin
            int gap;
            gap = quiet ? 0 : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                drive_idle(quiet);
                bus.input_buffer_ready = 1'b0;
                tick("idle", ev(0, 0, 0, 0, 0, 0, 0));
            end
            drive_idle(quiet);
            bus.input_buffer_ready   = 1'b1;
            bus.last_block_in_buffer = (b == nblk - 1);
            if (b == nblk - 1) bus.out_blocks = OBW'(ob);
            tick("absorb", ev(1, 0, 1, 0, 0, 0, 0));
            for (int r = 0; r < int'(NR); r++) begin
                drive_idle(quiet);
                if (r == abort_round && b == 0) begin
                    rst = 1'b1;
                    tick("rst_mid", ev(0, 0, 0, 0, 0, 0, 0));
                    rst = 1'b0;
                    drive_idle(1'b1);
                    tick("rst_release", ev(0, 1, 0, 0, 0, 0, 0));
                    return;
                end
                tick("round", ev(0, 0, 0, 1, r, 0, 0));
            end
        end
        for (int k = 1; k <= eff; k++) begin
            for (int h = 0; h < bp; h++) begin
                drive_idle(quiet);
                bus.output_buffer_ready = 1'b1;
                tick("hold", ev(0, 0, 0, 0, 0, 0, 0));
            end
            drive_idle(quiet);
            bus.output_buffer_ready = 1'b0;
            tick("load", ev(0, 0, 0, 0, 0, 1, k == eff));
            if (k < eff) begin
                for (int r = 0; r < int'(NR); r++) begin
                    drive_idle(quiet);
                    tick("squeeze", ev(0, 0, 0, 1, r, 0, 0));
                end
            end
        end
        drive_idle(quiet);
        tick("clear", ev(0, 1, 0, 0, 0, 0, 0));
    endtask

    initial begin
        drive_idle(1'b1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            drive_idle(i == 0);
            tick("in_reset", ev(0, 0, 0, 0, 0, 0, 0));
        end
        rst = 1'b0;
        drive_idle(1'b1);
        tick("post_reset", ev(0, 1, 0, 0, 0, 0, 0));

        run_message(1, 1, 0, -1, 1'b1);
        run_message(2, 1, 0, -1, 1'b1);
        run_message(1, 3, 0, -1, 1'b1);
        run_message(1, 1, 10, -1, 1'b1);
        run_message(1, 0, 0, -1, 1'b1);
        run_message(1, 0, 0, 12, 1'b1);
        run_message(1, 1, 0, -1, 1'b1);

        for (int m = 0; m < 25; m++) begin
            int ab;
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NR - 1)) : -1;
            run_message(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 4)), ab, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
